monitor_verdict_drain: RTL and testbench

- Sits downstream of the RTLola monitor `topEntity` and consumes its output streams: outA/aktvOutA (event-based) and outB/aktvOutB (time-based, sliding window).
- Each activation is time-stamped with a cycle counter and the record is buffered in a FIFO.
- Records are serialized as 64-bit words on a valid/ready stream to the host/trace sink.
- Drops caused by back-pressure are counted and flagged, never silently hidden.

---
 rtl/monitor_pkg.sv | 16 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/monitor_verdict_drain.sv | 76 +++++++
 tb/tb_monitor_verdict_drain.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// monitor_pkg: shared widths, record type, serializer states and header packing
package monitor_pkg;
    localparam int TS_W   = 62;
    localparam int DATA_W = 64;
    typedef struct packed {
        logic              fa;
        logic              fb;
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } rec_t;
    typedef enum logic [1:0] {IDLE, HDR, WA, WB} state_t;
    function automatic logic [DATA_W-1:0] pack_hdr(input rec_t r);
        return {r.fa, r.fb, r.ts};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count
//   clk/rst (sync, active-low), push/din write, pop read, dout = current head,
//   count = occupancy, full/empty derived from count. A push is refused when full
//   before the edge, even if a pop happens on that same edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    always_comb begin
        full    = count == CW'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/monitor_verdict_drain.sv
// monitor_verdict_drain: timestamps monitor activations, queues them, streams them as 64-bit words
//   en/outA/aktvOutA/outB/aktvOutB: monitor side; m_data/m_valid/m_ready/m_last: output stream;
//   drop_cnt: saturating count of records refused by a full queue; overflow: sticky drop flag.
module monitor_verdict_drain
    import monitor_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] outA,
    input  logic              aktvOutA,
    input  logic [DATA_W-1:0] outB,
    input  logic              aktvOutB,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [TS_W-1:0] ts;
    rec_t            head;
    logic [CW-1:0]   count;
    logic            full, empty, cap, xfer, pop, more;
    state_t          state, state_nx;
    assign cap  = en && (aktvOutA || aktvOutB);
    assign xfer = m_valid && m_ready;
    assign pop  = xfer && m_last;
    // a record landing on the same edge as the pop keeps the stream gapless
    assign more = count > CW'(1) || (cap && !full);
    sync_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .din   ({aktvOutA, aktvOutB, ts, outA, outB}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts       <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            ts    <= ts + TS_W'(en);
            state <= state_nx;
            if (cap && full) begin
                drop_cnt <= drop_cnt + DROP_W'(drop_cnt != '1);
                overflow <= 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = empty ? IDLE : HDR;
            HDR:  if (xfer) state_nx = head.fa ? WA : WB;
            WA:   if (xfer) state_nx = head.fb ? WB : (more ? HDR : IDLE);
            WB:   if (xfer) state_nx = more ? HDR : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        m_valid = state != IDLE;
        m_data  = state == HDR ? pack_hdr(head) : state == WA ? head.a : state == WB ? head.b : '0;
        m_last  = state == WB || (state == WA && !head.fb);
    end
endmodule

// File: tb/tb_monitor_verdict_drain.sv
// tb_monitor_verdict_drain: directed vectors with hand-computed expectations
module tb_monitor_verdict_drain;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, aktvOutA = 1'b0, aktvOutB = 1'b0, m_ready = 1'b0;
    logic [63:0] outA = '0, outB = '0, m_data;
    logic        m_valid, m_last, overflow;
    logic [15:0] drop_cnt;
    int          n_tests = 0, n_fail = 0;

    monitor_verdict_drain #(.DEPTH(8), .DROP_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .outA     (outA),
        .aktvOutA (aktvOutA),
        .outB     (outB),
        .aktvOutB (aktvOutB),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b0;
        en = 1'b1;
        aktvOutA = 1'b0;
        aktvOutB = 1'b0;
        m_ready = rdy;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [63:0] exp_w [3];
    logic [15:0] pat;
    int          idx;

    initial begin
        // 1: single A event at ts=5
        do_reset(1'b1);
        check("t1_rst_valid", m_valid, 0);
        check("t1_rst_data", m_data, 0);
        check("t1_rst_last", m_last, 0);
        check("t1_rst_drop", drop_cnt, 0);
        check("t1_rst_ovf", overflow, 0);
        idle_ticks(5);
        aktvOutA = 1'b1;
        outA = 64'd7;
        tick();
        aktvOutA = 1'b0;
        check("t1_lat_valid", m_valid, 0);
        tick();
        check("t1_hdr_valid", m_valid, 1);
        check("t1_hdr", m_data, 64'h8000_0000_0000_0005);
        check("t1_hdr_last", m_last, 0);
        tick();
        check("t1_a", m_data, 64'd7);
        check("t1_a_last", m_last, 1);
        tick();
        check("t1_end_valid", m_valid, 0);

        // 2: both streams at ts=3
        do_reset(1'b1);
        idle_ticks(3);
        aktvOutA = 1'b1;
        aktvOutB = 1'b1;
        outA = -64'sd2;
        outB = 64'd9;
        tick();
        aktvOutA = 1'b0;
        aktvOutB = 1'b0;
        tick();
        check("t2_hdr", m_data, 64'hC000_0000_0000_0003);
        check("t2_hdr_last", m_last, 0);
        tick();
        check("t2_a", m_data, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t2_a_last", m_last, 0);
        tick();
        check("t2_b", m_data, 64'd9);
        check("t2_b_last", m_last, 1);
        tick();
        check("t2_end_valid", m_valid, 0);

        // 3: overflow with a stalled sink, then gapless drain
        do_reset(1'b0);
        aktvOutB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            outB = 64'd100 + 64'(i);
            tick();
        end
        aktvOutB = 1'b0;
        check("t3_drop", drop_cnt, 2);
        check("t3_ovf", overflow, 1);
        m_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            check($sformatf("t3_hdr_valid%0d", r), m_valid, 1);
            check($sformatf("t3_hdr%0d", r), m_data, 64'h4000_0000_0000_0000 | 64'(r));
            check($sformatf("t3_hdr_last%0d", r), m_last, 0);
            tick();
            check($sformatf("t3_b_valid%0d", r), m_valid, 1);
            check($sformatf("t3_b%0d", r), m_data, 64'd100 + 64'(r));
            check($sformatf("t3_b_last%0d", r), m_last, 1);
            tick();
        end
        check("t3_end_valid", m_valid, 0);
        check("t3_drop_hold", drop_cnt, 2);

        // 4: irregular back-pressure across a three-word record
        do_reset(1'b0);
        aktvOutA = 1'b1;
        aktvOutB = 1'b1;
        outA = 64'd5;
        outB = 64'd6;
        tick();
        aktvOutA = 1'b0;
        aktvOutB = 1'b0;
        tick();
        exp_w[0] = 64'hC000_0000_0000_0000;
        exp_w[1] = 64'd5;
        exp_w[2] = 64'd6;
        pat = 16'b1011_0010_0110_0100;
        idx = 0;
        for (int i = 0; i < 16 && idx < 3; i++) begin
            m_ready = pat[i];
            check($sformatf("t4_valid%0d", i), m_valid, 1);
            check($sformatf("t4_data%0d", i), m_data, exp_w[idx]);
            check($sformatf("t4_last%0d", i), m_last, idx == 2);
            tick();
            if (m_ready) idx++;
        end
        check("t4_done", idx, 3);
        check("t4_end_valid", m_valid, 0);

        // 5: enable freeze ignores events and holds ts
        do_reset(1'b1);
        idle_ticks(2);
        en = 1'b0;
        aktvOutA = 1'b1;
        outA = 64'd11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_frz_valid%0d", i), m_valid, 0);
        end
        en = 1'b1;
        outA = 64'd3;
        tick();
        aktvOutA = 1'b0;
        tick();
        check("t5_hdr", m_data, 64'h8000_0000_0000_0002);
        tick();
        check("t5_a", m_data, 64'd3);

        // 6: reset in the middle of a data word
        do_reset(1'b0);
        aktvOutA = 1'b1;
        for (int i = 0; i < 9; i++) begin
            outA = 64'(i + 1);
            tick();
        end
        aktvOutA = 1'b0;
        check("t6_drop", drop_cnt, 1);
        m_ready = 1'b1;
        tick();
        check("t6_wa_data", m_data, 64'd1);
        check("t6_wa_last", m_last, 1);
        rst = 1'b0;
        tick();
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        check("t6_rst_drop", drop_cnt, 0);
        check("t6_rst_ovf", overflow, 0);
        rst = 1'b1;
        idle_ticks(2);
        check("t6_empty_valid", m_valid, 0);
        aktvOutA = 1'b1;
        outA = 64'd42;
        tick();
        aktvOutA = 1'b0;
        tick();
        check("t6_hdr", m_data, 64'h8000_0000_0000_0002);
        tick();
        check("t6_a", m_data, 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
